// File: rtl/bkm_pkg.sv
// Shared encodings for the BKM step datapath.
// BKM_STEP_SAT_EN selects saturating instead of wrapping results.
package bkm_pkg;

  localparam logic [1:0] DIG_ZERO  = 2'b00;
  localparam logic [1:0] DIG_POS   = 2'b01;
  localparam logic [1:0] DIG_NEG   = 2'b11;

  localparam logic [1:0] FMT_TRUNC = 2'b00;
  localparam logic [1:0] FMT_RND   = 2'b01;

  localparam logic       MODE_E    = 1'b0;
  localparam logic       MODE_L    = 1'b1;

`ifdef BKM_STEP_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

endpackage

// File: rtl/bkm_cplx_shift_add.sv
// Complex shift-and-add for the E-side pair, CSD in and canonical CSD out.
// Honours BKM_STEP_SAT_EN through bkm_pkg::SAT_EN.
module bkm_cplx_shift_add
  import bkm_pkg::*;
#(
  parameter int W     = 8,
  parameter int LOG2N = 3
) (
  input  logic [1:0]       fmt,
  input  logic [LOG2N-1:0] sh,
  input  logic [1:0]       d_x,
  input  logic [1:0]       d_y,
  input  logic [2*W-1:0]   x,
  input  logic [2*W-1:0]   y,
  output logic [2*W-1:0]   x_next,
  output logic [2*W-1:0]   y_next
);

  localparam int EW = W + 3;

  function automatic logic [W-1:0] csd2bin(
    input logic [2*W-1:0] c
  );
    logic [W-1:0] acc;
    acc = '0;
    for (int i = 0; i < W; i++) begin
      unique case (1'b1)
        (c[2*i+:2] == DIG_POS): acc = acc + (W'(1) << i);
        (c[2*i+:2] == DIG_NEG): acc = acc - (W'(1) << i);
        default: ;
      endcase
    end
    return acc;
  endfunction

  // Carry-driven NAF recoding; the carry out of the top digit is dropped (mod 2^W).
  function automatic logic [2*W-1:0] bin2csd(
    input logic [W-1:0] b
  );
    logic [2*W-1:0] r;
    logic [W:0]     e;
    logic           c;
    r = '0;
    e = {1'b0, b};
    c = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (e[i] ^ c) begin
        if (e[i+1]) begin
          r[2*i+:2] = DIG_NEG;
          c = 1'b1;
        end else begin
          r[2*i+:2] = DIG_POS;
          c = 1'b0;
        end
      end else begin
        c = e[i] & c;
      end
    end
    return r;
  endfunction

  function automatic logic signed [EW-1:0] term(
    input logic [1:0]       d,
    input logic [W-1:0]     a,
    input logic [LOG2N-1:0] s,
    input logic             rnd
  );
    logic signed [EW-1:0] ext;
    logic signed [EW-1:0] p;
    logic signed [EW-1:0] q;
    logic signed [EW-1:0] t;
    ext = {{(EW-W){a[W-1]}}, a};
    unique case (1'b1)
      (d == DIG_POS): p = ext;
      (d == DIG_NEG): p = -ext;
      default:        p = '0;
    endcase
    q = p >>> s;
    t = (s == '0) ? '0 : (p >>> (s - 1'b1));
    return rnd ? q + {{(EW-1){1'b0}}, t[0]} : q;
  endfunction

  function automatic logic [W-1:0] fit(
    input logic signed [EW-1:0] s
  );
    logic ovf;
    ovf = s[EW-1:W-1] != {(EW-W+1){s[W-1]}};
    if (SAT_EN && ovf)
      return s[EW-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    return s[W-1:0];
  endfunction

  logic [W-1:0]         xb;
  logic [W-1:0]         yb;
  logic                 rnd;
  logic signed [EW-1:0] xs;
  logic signed [EW-1:0] ys;

  assign xb  = csd2bin(x);
  assign yb  = csd2bin(y);
  assign rnd = (fmt == FMT_RND);

  always_comb begin
    xs = {{(EW-W){xb[W-1]}}, xb}
       + term(d_x, xb, sh, rnd)
       - term(d_y, yb, sh, rnd);
    ys = {{(EW-W){yb[W-1]}}, yb}
       + term(d_x, yb, sh, rnd)
       + term(d_y, xb, sh, rnd);
  end

  assign x_next = bin2csd(fit(xs));
  assign y_next = bin2csd(fit(ys));

endmodule

// File: rtl/bkm_step_core.sv
// One registered complex BKM iteration: E-side in CSD, L-side in binary.
// BKM_STEP_SAT_EN saturates X', Y', u', v' instead of wrapping.
module bkm_step_core
  import bkm_pkg::*;
#(
  parameter int W     = 8,
  parameter int LOG2W = 3,
  parameter int N     = 8,
  parameter int LOG2N = 3
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             srst,
  input  logic             enable,
  input  logic             mode,
  input  logic [1:0]       format,
  input  logic [LOG2N-1:0] n,
  input  logic [1:0]       d_x_n,
  input  logic [1:0]       d_y_n,
  input  logic [2*W-1:0]   X_n,
  input  logic [2*W-1:0]   Y_n,
  input  logic [2*W-1:0]   lut_X,
  input  logic [2*W-1:0]   lut_Y,
  input  logic [W-1:0]     u_n,
  input  logic [W-1:0]     v_n,
  input  logic [W-1:0]     lut_u,
  input  logic [W-1:0]     lut_v,
  output logic [2*W-1:0]   X_np1,
  output logic [2*W-1:0]   Y_np1,
  output logic [W-1:0]     u_np1,
  output logic [W-1:0]     v_np1
);

  function automatic logic [W-1:0] fit(
    input logic [W:0] s
  );
    if (SAT_EN && (s[W] != s[W-1]))
      return s[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    return s[W-1:0];
  endfunction

  logic [2*W-1:0] x_next;
  logic [2*W-1:0] y_next;
  logic [W:0]     u_sum;
  logic [W:0]     v_sum;
  logic           unused;

  // The CSD LUT operands are reserved and deliberately not part of the datapath.
  assign unused = ^{lut_X, lut_Y};

  bkm_cplx_shift_add #(
    .W     (W),
    .LOG2N (LOG2N)
  ) u_shift_add (
    .fmt    (format),
    .sh     (n),
    .d_x    (d_x_n),
    .d_y    (d_y_n),
    .x      (X_n),
    .y      (Y_n),
    .x_next (x_next),
    .y_next (y_next)
  );

  always_comb begin
    if (mode == MODE_L) begin
      u_sum = {u_n[W-1], u_n} + {lut_u[W-1], lut_u};
      v_sum = {v_n[W-1], v_n} + {lut_v[W-1], lut_v};
    end else begin
      u_sum = {u_n[W-1], u_n} - {lut_u[W-1], lut_u};
      v_sum = {v_n[W-1], v_n} - {lut_v[W-1], lut_v};
    end
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      X_np1 <= '0;
      Y_np1 <= '0;
      u_np1 <= '0;
      v_np1 <= '0;
    end else if (srst) begin
      X_np1 <= '0;
      Y_np1 <= '0;
      u_np1 <= '0;
      v_np1 <= '0;
    end else if (enable) begin
      X_np1 <= x_next;
      Y_np1 <= y_next;
      u_np1 <= fit(u_sum);
      v_np1 <= fit(v_sum);
    end
  end

endmodule

// File: tb/tb_bkm_step_core.sv
// Directed bench for bkm_step_core (W=8, N=8).
// Expected values follow BKM_STEP_SAT_EN when it is defined.
module tb_bkm_step_core;

  logic        clk;
  logic        arst;
  logic        srst;
  logic        enable;
  logic        mode;
  logic [1:0]  format;
  logic [2:0]  n;
  logic [1:0]  d_x_n;
  logic [1:0]  d_y_n;
  logic [15:0] X_n;
  logic [15:0] Y_n;
  logic [15:0] lut_X;
  logic [15:0] lut_Y;
  logic [7:0]  u_n;
  logic [7:0]  v_n;
  logic [7:0]  lut_u;
  logic [7:0]  lut_v;
  logic [15:0] X_np1;
  logic [15:0] Y_np1;
  logic [7:0]  u_np1;
  logic [7:0]  v_np1;

  int checks = 0;
  int errors = 0;

  bkm_step_core #(.W(8), .LOG2W(3), .N(8), .LOG2N(3)) dut (
    .clk    (clk),
    .arst   (arst),
    .srst   (srst),
    .enable (enable),
    .mode   (mode),
    .format (format),
    .n      (n),
    .d_x_n  (d_x_n),
    .d_y_n  (d_y_n),
    .X_n    (X_n),
    .Y_n    (Y_n),
    .lut_X  (lut_X),
    .lut_Y  (lut_Y),
    .u_n    (u_n),
    .v_n    (v_n),
    .lut_u  (lut_u),
    .lut_v  (lut_v),
    .X_np1  (X_np1),
    .Y_np1  (Y_np1),
    .u_np1  (u_np1),
    .v_np1  (v_np1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] b2c(input logic [7:0] v);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[2*i+:2] = v[i] ? 2'b01 : 2'b00;
    return r;
  endfunction

  function automatic logic signed [7:0] c2b(input logic [15:0] c);
    logic signed [7:0] acc;
    acc = '0;
    for (int i = 0; i < 8; i++) begin
      if (c[2*i+:2] == 2'b01) acc = acc + 8'sd1 * (8'sd1 <<< i);
      if (c[2*i+:2] == 2'b11) acc = acc - 8'sd1 * (8'sd1 <<< i);
    end
    return acc;
  endfunction

  function automatic bit canon(input logic [15:0] c);
    for (int i = 0; i < 7; i++)
      if (c[2*i] && c[2*i+2]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(
    input logic       m,
    input logic [1:0] f,
    input logic [2:0] sh,
    input logic [1:0] dx,
    input logic [1:0] dy,
    input logic [7:0] x,
    input logic [7:0] y,
    input logic [7:0] u,
    input logic [7:0] lu,
    input logic [7:0] v,
    input logic [7:0] lv
  );
    mode = m; format = f; n = sh;
    d_x_n = dx; d_y_n = dy;
    X_n = b2c(x); Y_n = b2c(y);
    u_n = u; lut_u = lu; v_n = v; lut_v = lv;
    lut_X = 16'($urandom); lut_Y = 16'($urandom);
  endtask

  task automatic test_reset();
    arst = 1'b1; srst = 1'b0; enable = 1'b0;
    drive(1'b0, 2'b00, 3'd1, 2'b01, 2'b00, 8'd64, 8'd3, 8'd9, 8'd1, 8'd7, 8'd2);
    #2 arst = 1'b0;
    #1;
    checks++;
    if ({X_np1, Y_np1, u_np1, v_np1} !== 48'd0) begin
      errors++;
      $display("FAIL reset_async got %h %h %h %h want 0", X_np1, Y_np1, u_np1, v_np1);
    end
    tick(); tick();
    arst = 1'b1;
    tick(); tick(); tick();
    checks++;
    if (X_np1 !== 16'd0) begin errors++; $display("FAIL reset_x got %h want 0", X_np1); end
    checks++;
    if (Y_np1 !== 16'd0) begin errors++; $display("FAIL reset_y got %h want 0", Y_np1); end
    checks++;
    if (u_np1 !== 8'd0) begin errors++; $display("FAIL reset_u got %h want 0", u_np1); end
    checks++;
    if (v_np1 !== 8'd0) begin errors++; $display("FAIL reset_v got %h want 0", v_np1); end
  endtask

  task automatic test_e_mode();
    enable = 1'b1;
    drive(1'b0, 2'b00, 3'd1, 2'b01, 2'b00, 8'd64, 8'd0, 8'd100, 8'd20, 8'd5, 8'd5);
    tick();
    checks++;
    if (c2b(X_np1) !== 8'sd96) begin errors++; $display("FAIL e_mode_x got %0d want 96", c2b(X_np1)); end
    checks++;
    if (c2b(Y_np1) !== 8'sd0) begin errors++; $display("FAIL e_mode_y got %0d want 0", c2b(Y_np1)); end
    checks++;
    if (u_np1 !== 8'd80) begin errors++; $display("FAIL e_mode_u got %0d want 80", $signed(u_np1)); end
    checks++;
    if (v_np1 !== 8'd0) begin errors++; $display("FAIL e_mode_v got %0d want 0", $signed(v_np1)); end
    checks++;
    if (!canon(X_np1)) begin errors++; $display("FAIL e_mode_canon got %b want canonical", X_np1); end
  endtask

  task automatic test_l_mode();
    drive(1'b1, 2'b00, 3'd2, 2'b00, 2'b01, 8'd16, 8'd8, 8'd100, 8'd20, 8'd0, 8'd0);
    tick();
    checks++;
    if (c2b(X_np1) !== 8'sd14) begin errors++; $display("FAIL l_mode_x got %0d want 14", c2b(X_np1)); end
    checks++;
    if (c2b(Y_np1) !== 8'sd12) begin errors++; $display("FAIL l_mode_y got %0d want 12", c2b(Y_np1)); end
    checks++;
    if (u_np1 !== 8'd120) begin errors++; $display("FAIL l_mode_u got %0d want 120", $signed(u_np1)); end
  endtask

  task automatic test_neg_digits();
    drive(1'b0, 2'b00, 3'd1, 2'b11, 2'b11, 8'd20, 8'd40, 8'hFB, 8'd10, 8'd0, 8'hFD);
    tick();
    checks++;
    if (c2b(X_np1) !== 8'sd30) begin errors++; $display("FAIL neg_x got %0d want 30", c2b(X_np1)); end
    checks++;
    if (c2b(Y_np1) !== 8'sd10) begin errors++; $display("FAIL neg_y got %0d want 10", c2b(Y_np1)); end
    checks++;
    if (u_np1 !== 8'hF1) begin errors++; $display("FAIL neg_u got %0d want -15", $signed(u_np1)); end
    checks++;
    if (v_np1 !== 8'd3) begin errors++; $display("FAIL neg_v got %0d want 3", $signed(v_np1)); end
  endtask

  task automatic test_overflow();
    logic signed [7:0] ex;
    logic [7:0]        eu;
    logic [7:0]        ev;
`ifdef BKM_STEP_SAT_EN
    ex = 8'sd127; eu = 8'h7F; ev = 8'h80;
`else
    ex = -8'sd2;  eu = 8'hC8; ev = 8'h38;
`endif
    drive(1'b1, 2'b00, 3'd0, 2'b01, 2'b00, 8'd127, 8'd0, 8'd100, 8'd100, 8'h9C, 8'h9C);
    tick();
    checks++;
    if (c2b(X_np1) !== ex) begin errors++; $display("FAIL ovf_x got %0d want %0d", c2b(X_np1), ex); end
    checks++;
    if (u_np1 !== eu) begin errors++; $display("FAIL ovf_u got %0d want %0d", $signed(u_np1), $signed(eu)); end
    drive(1'b0, 2'b00, 3'd7, 2'b01, 2'b00, 8'h9C, 8'd50, 8'd0, 8'd0, 8'h9C, 8'd100);
    tick();
    checks++;
    if (v_np1 !== ev) begin errors++; $display("FAIL ovf_v got %0d want %0d", $signed(v_np1), $signed(ev)); end
    checks++;
    if (c2b(X_np1) !== -8'sd101) begin errors++; $display("FAIL shift7_x got %0d want -101", c2b(X_np1)); end
  endtask

  task automatic test_back_to_back_hold();
    drive(1'b0, 2'b00, 3'd1, 2'b01, 2'b00, 8'd64, 8'd0, 8'd100, 8'd20, 8'd5, 8'd5);
    tick();
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'b01, 3'(i), 2'b11, 2'b01, 8'(i * 7 + 3), 8'd33, 8'd1, 8'd2, 8'd3, 8'd4);
      tick();
    end
    checks++;
    if (c2b(X_np1) !== 8'sd96) begin errors++; $display("FAIL hold_x got %0d want 96", c2b(X_np1)); end
    checks++;
    if (c2b(Y_np1) !== 8'sd0) begin errors++; $display("FAIL hold_y got %0d want 0", c2b(Y_np1)); end
    checks++;
    if (u_np1 !== 8'd80) begin errors++; $display("FAIL hold_u got %0d want 80", $signed(u_np1)); end
    checks++;
    if (v_np1 !== 8'd0) begin errors++; $display("FAIL hold_v got %0d want 0", $signed(v_np1)); end
    enable = 1'b1;
    srst = 1'b1;
    tick();
    srst = 1'b0;
    checks++;
    if ({X_np1, Y_np1, u_np1, v_np1} !== 48'd0) begin
      errors++;
      $display("FAIL srst got %h %h %h %h want 0", X_np1, Y_np1, u_np1, v_np1);
    end
  endtask

  task automatic test_rounding();
    logic [1:0]        fm [5];
    logic [7:0]        xi [5];
    logic signed [7:0] xe [5];
    fm = '{2'b01, 2'b00, 2'b01, 2'b00, 2'b10};
    xi = '{8'd6, 8'd6, 8'hFA, 8'hFA, 8'd6};
    xe = '{8'sd8, 8'sd7, -8'sd7, -8'sd8, 8'sd7};
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, fm[i], 3'd2, 2'b01, 2'b00, xi[i], 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
      tick();
      checks++;
      if (c2b(X_np1) !== xe[i]) begin
        errors++;
        $display("FAIL round_%0d got %0d want %0d", i, c2b(X_np1), xe[i]);
      end
    end
  endtask

  task automatic test_reserved();
    drive(1'b0, 2'b01, 3'd2, 2'b10, 2'b10, 8'd77, 8'hC5, 8'd0, 8'd0, 8'd0, 8'd0);
    tick();
    checks++;
    if (c2b(X_np1) !== 8'sd77) begin errors++; $display("FAIL pass_x got %0d want 77", c2b(X_np1)); end
    checks++;
    if (c2b(Y_np1) !== -8'sd59) begin errors++; $display("FAIL pass_y got %0d want -59", c2b(Y_np1)); end
    drive(1'b0, 2'b10, 3'd2, 2'b01, 2'b10, 8'd6, 8'd100, 8'd0, 8'd0, 8'd0, 8'd0);
    tick();
    checks++;
    if (c2b(X_np1) !== 8'sd7) begin errors++; $display("FAIL rsv_x got %0d want 7", c2b(X_np1)); end
    checks++;
    if (c2b(Y_np1) !== 8'sd125) begin errors++; $display("FAIL rsv_y got %0d want 125", c2b(Y_np1)); end
    checks++;
    if (!canon(Y_np1)) begin errors++; $display("FAIL rsv_canon got %b want canonical", Y_np1); end
  endtask

  task automatic test_async_mid();
    drive(1'b0, 2'b00, 3'd1, 2'b01, 2'b00, 8'd64, 8'd0, 8'd100, 8'd20, 8'd5, 8'd5);
    tick();
    #2 arst = 1'b0;
    #1;
    checks++;
    if ({X_np1, Y_np1, u_np1, v_np1} !== 48'd0) begin
      errors++;
      $display("FAIL arst_mid got %h %h %h %h want 0", X_np1, Y_np1, u_np1, v_np1);
    end
    tick();
    checks++;
    if (u_np1 !== 8'd0) begin errors++; $display("FAIL arst_held_u got %0d want 0", $signed(u_np1)); end
    arst = 1'b1;
    tick();
    checks++;
    if (u_np1 !== 8'd80) begin errors++; $display("FAIL arst_rel_u got %0d want 80", $signed(u_np1)); end
  endtask

  initial begin
    test_reset();
    test_e_mode();
    test_l_mode();
    test_neg_digits();
    test_overflow();
    test_back_to_back_hold();
    test_rounding();
    test_reserved();
    test_async_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
